// File: rtl/wired_stream_pkg.sv
// rtl/wired_stream_pkg.sv - shared valid/ready stream helpers
package wired_stream_pkg;

  localparam int unsigned STREAM_DATA_W = 32;

  // Explicit wrap so non-power-of-2 depths index correctly.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/wired_skidbuf_mem.sv
// rtl/wired_skidbuf_mem.sv - unreset flop array, one write port, async read mux
module wired_skidbuf_mem
  import wired_stream_pkg::*;
#(
  parameter type T     = logic [STREAM_DATA_W-1:0],
  parameter int  DEPTH = 2,
  parameter int  PTR_W = 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  T                 wdata,
  input  logic [PTR_W-1:0] raddr,
  output T                 rdata
);

  T mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wired_skidbuf.sv
// rtl/wired_skidbuf.sv - backward-registered stream slice on a circular buffer
module wired_skidbuf
  import wired_stream_pkg::*;
#(
  parameter type  T     = logic [STREAM_DATA_W-1:0],
  parameter int   DEPTH = 2,
  localparam int  CNT_W = $clog2(DEPTH + 1),
  localparam int  PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             inp_valid_i,
  output logic             inp_ready_o,
  input  T                 inp_i,
  output logic             oup_valid_o,
  input  logic             oup_ready_i,
  output T                 oup_o,
  output logic [CNT_W-1:0] cnt_o
);

  if (DEPTH < 2) begin : g_depth_chk
    $error("wired_skidbuf: DEPTH must be >= 2");
  end

  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_next;
  logic             ready_q, valid_q;
  logic             push, pop;

  assign push = inp_valid_i && ready_q;
  assign pop  = valid_q && oup_ready_i;

  always_comb begin
    cnt_next = cnt_q;
    if (push && !pop)      cnt_next = cnt_q + CNT_W'(1);
    else if (pop && !push) cnt_next = cnt_q - CNT_W'(1);
  end

  // Ready and valid are both derived from the next count, so neither
  // output sees oup_ready_i through combinational logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      if (push) wptr_q <= PTR_W'(ptr_inc(32'(wptr_q), DEPTH));
      if (pop)  rptr_q <= PTR_W'(ptr_inc(32'(rptr_q), DEPTH));
      cnt_q   <= cnt_next;
      ready_q <= (cnt_next < CNT_W'(DEPTH));
      valid_q <= (cnt_next != '0);
    end
  end

  wired_skidbuf_mem #(
    .T     (T),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push && !flush_i && !rst),
    .waddr (wptr_q),
    .wdata (inp_i),
    .raddr (rptr_q),
    .rdata (oup_o)
  );

  assign inp_ready_o = ready_q;
  assign oup_valid_o = valid_q;
  assign cnt_o       = cnt_q;

endmodule

// File: tb/tb_wired_skidbuf.sv
// tb/tb_wired_skidbuf.sv - scoreboard bench for DEPTH=2 and DEPTH=3 slices
module tb_wired_skidbuf;

  logic        clk, rst;
  logic        v2, r2, ov2, or2, f2;
  logic [31:0] d2, o2;
  logic [1:0]  c2;
  logic        v3, r3, ov3, or3, f3;
  logic [31:0] d3, o3;
  logic [1:0]  c3;

  logic [31:0] q2[$];
  logic [31:0] q3[$];
  int          checks, passed, rx3;

  wired_skidbuf #(.DEPTH(2)) u2 (
    .clk(clk), .rst(rst), .flush_i(f2), .inp_valid_i(v2), .inp_ready_o(r2), .inp_i(d2),
    .oup_valid_o(ov2), .oup_ready_i(or2), .oup_o(o2), .cnt_o(c2)
  );

  wired_skidbuf #(.DEPTH(3)) u3 (
    .clk(clk), .rst(rst), .flush_i(f3), .inp_valid_i(v3), .inp_ready_o(r3), .inp_i(d3),
    .oup_valid_o(ov3), .oup_ready_i(or3), .oup_o(o3), .cnt_o(c3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle on the DEPTH=2 slice; accepted beats go into the scoreboard, delivered beats are popped and compared.
  task automatic cyc2(input logic v, input logic [31:0] d, input logic ordy, input logic fl);
    logic [31:0] exp;
    v2 = v; d2 = d; or2 = ordy; f2 = fl;
    #1;
    if (ov2 && ordy && !fl) begin
      checks++;
      if (q2.size() == 0) $display("FAIL d2_data: got %0h with empty scoreboard", o2);
      else begin
        exp = q2.pop_front();
        if (o2 !== exp) $display("FAIL d2_data: got %0h expected %0h", o2, exp);
        else passed++;
      end
    end
    if (v && r2 && !fl) q2.push_back(d);
    if (fl) q2.delete();
    @(posedge clk); #1;
  endtask

  task automatic cyc3(input logic v, input logic [31:0] d, input logic ordy);
    logic [31:0] exp;
    v3 = v; d3 = d; or3 = ordy; f3 = 1'b0;
    #1;
    if (ov3 && ordy) begin
      checks++;
      rx3++;
      if (q3.size() == 0) $display("FAIL d3_data: got %0h with empty scoreboard", o3);
      else begin
        exp = q3.pop_front();
        if (o3 !== exp) $display("FAIL d3_data: got %0h expected %0h", o3, exp);
        else passed++;
      end
    end
    if (v && r3) q3.push_back(d);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    v2 = 0; d2 = 0; or2 = 0; f2 = 0;
    v3 = 0; d3 = 0; or3 = 0; f3 = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (r2 !== 1'b0 || r3 !== 1'b0) $display("FAIL reset_ready: got %b/%b expected 0/0", r2, r3); else passed++;
      checks++; if (ov2 !== 1'b0 || ov3 !== 1'b0) $display("FAIL reset_valid: got %b/%b expected 0/0", ov2, ov3); else passed++;
      checks++; if (c2 !== 2'd0 || c3 !== 2'd0) $display("FAIL reset_cnt: got %0d/%0d expected 0/0", c2, c3); else passed++;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (r2 !== 1'b1 || r3 !== 1'b1) $display("FAIL release_ready: got %b/%b expected 1/1", r2, r3); else passed++;
    checks++; if (ov2 !== 1'b0 || c2 !== 2'd0) $display("FAIL release_state: got valid %b cnt %0d expected 0 0", ov2, c2); else passed++;
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 8; i++) begin
      cyc2(1'b1, 32'h11 + i, 1'b1, 1'b0);
      checks++; if (c2 !== 2'd1) $display("FAIL stream_cnt: got %0d expected 1", c2); else passed++;
      checks++; if (ov2 !== 1'b1 || r2 !== 1'b1) $display("FAIL stream_flags: got valid %b ready %b expected 1 1", ov2, r2); else passed++;
      checks++; if (o2 !== 32'h11 + i) $display("FAIL stream_latency: got %0h expected %0h", o2, 32'h11 + i); else passed++;
    end
    cyc2(1'b0, 32'h0, 1'b1, 1'b0);
    checks++; if (c2 !== 2'd0 || ov2 !== 1'b0) $display("FAIL stream_drain: got cnt %0d valid %b expected 0 0", c2, ov2); else passed++;
    checks++; if (q2.size() != 0) $display("FAIL stream_left: got %0d expected 0", q2.size()); else passed++;
  endtask

  task automatic test_backpressure();
    cyc2(1'b1, 32'hA, 1'b0, 1'b0);
    cyc2(1'b1, 32'hB, 1'b0, 1'b0);
    checks++; if (c2 !== 2'd2 || r2 !== 1'b0) $display("FAIL full_state: got cnt %0d ready %b expected 2 0", c2, r2); else passed++;
    cyc2(1'b1, 32'hC, 1'b0, 1'b0);
    checks++; if (c2 !== 2'd2 || r2 !== 1'b0 || o2 !== 32'hA) $display("FAIL full_hold: got cnt %0d ready %b head %0h expected 2 0 a", c2, r2, o2); else passed++;
    cyc2(1'b1, 32'hC, 1'b1, 1'b0);
    checks++; if (c2 !== 2'd1 || r2 !== 1'b1) $display("FAIL full_pop: got cnt %0d ready %b expected 1 1", c2, r2); else passed++;
    cyc2(1'b1, 32'hC, 1'b0, 1'b0);
    checks++; if (c2 !== 2'd2 || o2 !== 32'hB) $display("FAIL full_accept: got cnt %0d head %0h expected 2 b", c2, o2); else passed++;
    for (int i = 0; i < 3; i++) cyc2(1'b0, 32'h0, 1'b1, 1'b0);
    checks++; if (c2 !== 2'd0 || q2.size() != 0) $display("FAIL full_drain: got cnt %0d left %0d expected 0 0", c2, q2.size()); else passed++;
  endtask

  task automatic test_wrap();
    int next, cyc;
    logic v;
    next = 0; cyc = 0; rx3 = 0;
    while ((next < 20 || rx3 < 20) && cyc < 400) begin
      v = (next < 20) && ($urandom_range(0, 3) != 0);
      if (v && r3) begin
        cyc3(1'b1, 32'(next), $urandom_range(0, 2) != 0);
        next++;
      end else cyc3(1'b0, 32'h0, $urandom_range(0, 2) != 0);
      checks++; if (int'(c3) != q3.size() || c3 > 2'd3) $display("FAIL wrap_cnt: got %0d expected %0d", c3, q3.size()); else passed++;
      cyc++;
    end
    checks++; if (rx3 != 20) $display("FAIL wrap_total: got %0d expected 20", rx3); else passed++;
  endtask

  task automatic test_flush();
    cyc2(1'b1, 32'h51, 1'b0, 1'b0);
    cyc2(1'b1, 32'h52, 1'b0, 1'b0);
    cyc2(1'b1, 32'h55, 1'b0, 1'b1);
    checks++; if (c2 !== 2'd0 || ov2 !== 1'b0 || r2 !== 1'b1) $display("FAIL flush_full: got cnt %0d valid %b ready %b expected 0 0 1", c2, ov2, r2); else passed++;
    cyc2(1'b1, 32'h53, 1'b0, 1'b0);
    cyc2(1'b1, 32'h56, 1'b1, 1'b1);
    checks++; if (c2 !== 2'd0 || ov2 !== 1'b0 || r2 !== 1'b1) $display("FAIL flush_push: got cnt %0d valid %b ready %b expected 0 0 1", c2, ov2, r2); else passed++;
    for (int i = 0; i < 2; i++) begin
      cyc2(1'b0, 32'h0, 1'b1, 1'b0);
      checks++; if (ov2 !== 1'b0) $display("FAIL flush_ghost: got valid %b data %0h expected 0", ov2, o2); else passed++;
    end
  endtask

  task automatic test_push_pop_full1();
    cyc2(1'b1, 32'h6, 1'b0, 1'b0);
    cyc2(1'b1, 32'h7, 1'b1, 1'b0);
    checks++; if (c2 !== 2'd1 || r2 !== 1'b1 || o2 !== 32'h7) $display("FAIL pushpop: got cnt %0d ready %b head %0h expected 1 1 7", c2, r2, o2); else passed++;
    cyc2(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_mid_reset();
    cyc2(1'b1, 32'h91, 1'b0, 1'b0);
    cyc2(1'b1, 32'h92, 1'b0, 1'b0);
    rst = 1'b1; v2 = 1'b0;
    @(posedge clk); #1;
    checks++; if (c2 !== 2'd0 || ov2 !== 1'b0 || r2 !== 1'b0) $display("FAIL midreset: got cnt %0d valid %b ready %b expected 0 0 0", c2, ov2, r2); else passed++;
    q2.delete();
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (r2 !== 1'b1 || ov2 !== 1'b0) $display("FAIL midreset_release: got ready %b valid %b expected 1 0", r2, ov2); else passed++;
  endtask

  initial begin
    checks = 0; passed = 0; rx3 = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_wrap();
    test_flush();
    test_push_pop_full1();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/wired_skidbuf.md
Name: wired_skidbuf

Overview:
- Backward-registered stream slice: the counterpart of the forward pipeline register.
- Cuts the combinational ready path. inp_ready_o comes from a flop, with no combinational path from oup_ready_i.
- Output valid and data also come from flops only.
- Placed between pipeline stages whose ready chains would otherwise form long combinational paths (issue/dispatch, LSU queues).
- Internally a DEPTH-entry circular buffer with a registered not-full flag and a synchronous flush.

Parameters:
- T, logic[31:0], payload type carried unchanged.
- DEPTH, 2, number of storage entries; must be >= 2; elaboration error otherwise.
- CNT_W, $clog2(DEPTH+1), derived width of the occupancy count; not overridable.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- flush_i  input  1  synchronous discard of all buffered entries.
- inp_valid_i  input  1  upstream valid.
- inp_ready_o  output  1  upstream ready; registered.
- inp_i  input  T  upstream payload.
- oup_valid_o  output  1  downstream valid; registered, equals count != 0.
- oup_ready_i  input  1  downstream ready.
- oup_o  output  T  head entry payload; registered storage muxed by the read pointer.
- cnt_o  output  CNT_W  current occupancy.

Behaviour:
- One clock domain; reset is synchronous and active-high, ports named clk / rst.
- Reset values:
  - oup_valid_o=0, inp_ready_o=0, cnt_o=0.
  - Read/write pointers = 0.
  - Storage is not reset.
- inp_ready_o rises to 1 in the first cycle after rst deasserts.
- push = inp_valid_i && inp_ready_o; pop = oup_valid_o && oup_ready_i. Both are evaluated in the same cycle.
- push: write inp_i at wptr; wptr advances modulo DEPTH (explicit wrap at DEPTH-1; DEPTH need not be a power of 2).
- pop: rptr advances modulo DEPTH.
- count_next = count + push - pop.
- ready_q_next = (count_next < DEPTH). inp_ready_o = ready_q, so it never depends combinationally on oup_ready_i.
- Latency: a beat accepted in cycle N is first visible on oup_o/oup_valid_o in cycle N+1. There is no fall-through.
- Throughput is 1 beat/cycle in steady state for DEPTH>=2.
- Full (count==DEPTH):
  - inp_ready_o=0.
  - A pop in that cycle raises inp_ready_o in the next cycle.
  - The upstream may hold valid; no beat is lost.
- Empty (count==0): oup_valid_o=0 and oup_o is don't-care.
- Push and pop when count==DEPTH-1: count is unchanged and ready stays 1.
- oup_o and oup_valid_o stay stable while oup_valid_o && !oup_ready_i (AXI-style hold). Upstream must obey the same rule on its side.
- flush_i=1 (when rst=0):
  - Next cycle: count=0, pointers=0, oup_valid_o=0, inp_ready_o=1.
  - Any push or pop in the flush cycle is discarded.
- flush and push together: the pushed beat is dropped.
- rst asserted mid-stream: all in-flight beats are dropped and the reset values apply the following cycle. rst has priority over flush_i.
- No X propagation on outputs after reset: oup_valid_o and inp_ready_o are always driven from reset flops.

Decomposition:
- Package wired_stream_pkg holds the shared valid/ready stream conventions. Contents:
  - Helper function ptr_inc(ptr, depth) for non-power-of-2 wrap.
  - Localparam default payload width 32.
- Natural sub-module: wired_skidbuf_mem.
  - DEPTH x T flop array with one write port (we, waddr, wdata) and a combinational read mux on raddr.
  - No reset.
- Top level holds pointers, counter, ready flop and flush/reset control.

Test Plan:
- Reset release: hold rst for 3 cycles, then release → inp_ready_o=0 during reset and 1 on the first cycle after; oup_valid_o=0 and cnt_o=0 throughout.
- Streaming: DEPTH=2, push 0x11..0x18 on consecutive cycles with oup_ready_i=1 → outputs 0x11..0x18 in order, 1-cycle latency, no bubbles, cnt_o=1 steady.
- Backpressure/full: oup_ready_i=0 and push 0xA, 0xB →
  - cnt_o=2; inp_ready_o=0 in the cycle after the second push.
  - 0xC held on the input is not accepted.
  - Raise oup_ready_i for 1 cycle → 0xA popped, inp_ready_o=1 next cycle, 0xC accepted; order 0xA, 0xB, 0xC.
- Wrap, DEPTH=3: push/pop random pattern over 20 beats (values 0..19) → in-order delivery across pointer wrap at 2→0; cnt_o never exceeds 3.
- Flush: with 2 entries held, assert flush_i together with push 0x55 → next cycle cnt_o=0, oup_valid_o=0, inp_ready_o=1; 0x55 never appears on oup_o.
- Simultaneous push+pop when full-1: DEPTH=2, count=1, push 0x7 and pop in the same cycle → count stays 1, inp_ready_o stays 1, next output 0x7.
